fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling instruction queue between the fetch stage and the decode stage. Captures each fetched instruction with its PC and compressed flag, and presents them in order to decode through a valid/ready handshake. Absorbs decode stalls without throttling fetch until the queue is full. Discards all contents on a pipeline flush (taken branch, jump, trap).

## Interface
- DEPTH, 4: number of entries; power of two, ≥2; any other value is an elaboration error.
- i_clock  in  1  clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; discards all entries.
- i_valid  in  1  fetch presents an instruction; driven by fetch as `!hazard`.
- i_inst  in  Inst  instruction, already expanded if it was compressed.
- i_instCompressed  in  1  original instruction was 16-bit.
- i_pc  in  InstAddr  PC of i_inst.
- o_ready  out  1  queue can accept; equals `!full`.
- o_valid  out  1  head entry valid; equals `!empty`.
- o_inst  out  Inst  head instruction.
- o_instCompressed  out  1  head compressed flag.
- o_pc  out  InstAddr  head PC.
- i_ready  in  1  decode accepts the head entry this cycle.
- o_count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Push when `i_valid && o_ready`. The entry {i_inst, i_instCompressed, i_pc} is written at wrPtr, and wrPtr increments.
- Pop when `o_valid && i_ready`. rdPtr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Count update: count_next = count + push − pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Full (count == DEPTH):
  - o_ready = 0 and incoming data is ignored.
  - A pop in the same cycle does not make o_ready high in that cycle. There is no combinational path from i_ready to o_ready.
- Empty (count == 0):
  - o_valid = 0; o_inst = 32'h0000_0013 (NOP), o_pc = 0, o_instCompressed = 0.
  - There is no input-to-output bypass.
- i_ready while o_valid = 0 has no effect.
- Flush has the highest priority. On the next edge, count and both pointers become 0. A push or pop in the flush cycle is discarded.
- There is no combinational path from any input to o_valid, o_ready or o_count. These are derived only from registered state.
- Reset values:
  - o_valid 0, o_ready 1, o_count 0.
  - o_inst NOP, o_pc 0, o_instCompressed 0.
  - Both pointers 0.
  - Storage contents need no reset.
- Asserting reset mid-operation drops all entries immediately (asynchronous). The queue accepts pushes on the first edge after deassertion.

## Timing
- Latency is 1 cycle from push to visibility. Push at edge N makes o_valid high after N if the queue was empty.
- Throughput is one push and one pop per cycle.
- A full queue drained by decode restores o_ready one cycle after the pop.
- After a flush, o_valid = 0 and o_ready = 1 in the following cycle. A push is accepted in that cycle.
- Head outputs are read combinationally from storage[rdPtr].

## Structure
- Shared Types package:
  - Add typedef `FetchEntry` = struct packed {Inst inst; logic compressed; InstAddr pc}.
  - Add constant `NOP_INST` = 32'h0000_0013.
- Sub-module `fetch_queue_ctrl` holds pointers, count, full/empty and flush logic. The top level holds the FetchEntry storage array and output muxing.

## Test plan
- Reset and single entry:
  - After reset: o_valid 0, o_ready 1, o_count 0, o_inst 32'h13.
  - Push pc 0x100, inst 0x00500093 → next cycle o_valid 1, o_pc 0x100, o_count 1.
- Fill and stall:
  - Push 4 entries (pc 0x0, 0x4, 0x8, 0xC) with i_ready 0 → o_count 4 and o_ready 0.
  - A fifth push (pc 0x10) is ignored; the head is still pc 0x0.
- Streaming:
  - i_valid and i_ready held high for 20 cycles with pc incrementing by 4 → o_count stays 1.
  - Output PCs come out in order, with no gaps after the first cycle.
- Wrap-around:
  - Push 6 and pop 6 interleaved so the pointers wrap past entry 3 → order is preserved and o_count returns to 0.
  - An entry with i_instCompressed 1 (pc 0x22) is reported with o_instCompressed 1.
- Flush:
  - With 3 entries queued, assert i_flush together with a push (pc 0x40) and a pop → next cycle o_count 0 and o_valid 0.
  - A push of pc 0x80 in the following cycle appears at the head one cycle later.
- Asynchronous reset:
  - With the queue full, assert i_reset low between edges → outputs take their reset values immediately.
  - After release, the first push is accepted normally.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// FetchEntry is the unit of storage; NOP_INST is what the head shows while empty.
package fetch_queue_pkg;

    typedef logic [31:0] Inst;
    typedef logic [31:0] InstAddr;

    typedef struct packed {
        Inst     inst;
        logic    compressed;
        InstAddr pc;
    } FetchEntry;

    localparam Inst NOP_INST = 32'h0000_0013;

    localparam FetchEntry EMPTY_ENTRY = '{inst: NOP_INST, compressed: 1'b0, pc: '0};

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode bus of the instruction queue: fetch push side, decode pop side, flush.
// The queue is the slave; fetch/decode (or a bench) drive it as master.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    logic                       i_flush;
    logic                       i_valid;
    Inst                        i_inst;
    logic                       i_instCompressed;
    InstAddr                    i_pc;
    logic                       o_ready;
    logic                       o_valid;
    Inst                        o_inst;
    logic                       o_instCompressed;
    InstAddr                    o_pc;
    logic                       i_ready;
    logic [$clog2(DEPTH+1)-1:0] o_count;

    modport slave (
        input  i_flush, i_valid, i_inst, i_instCompressed, i_pc, i_ready,
        output o_ready, o_valid, o_inst, o_instCompressed, o_pc, o_count
    );

    modport master (
        output i_flush, i_valid, i_inst, i_instCompressed, i_pc, i_ready,
        input  o_ready, o_valid, o_inst, o_instCompressed, o_pc, o_count
    );

endinterface

// File: rtl/fetch_queue_ctrl.sv
// Pointer/occupancy control for fetch_queue: push/pop qualification, flush, full/empty.
// full/empty come straight from the count register, so no input reaches them combinationally.
module fetch_queue_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_req,
    input  logic          pop_req,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          push
);

    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = push_req && !full && !flush;
    assign pop   = pop_req && !empty && !flush;

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: holds {inst, compressed, pc} entries in order.
// Head is read combinationally from storage; an empty queue presents a NOP at pc 0.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    fetch_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    FetchEntry     mem [DEPTH];
    FetchEntry     head;

    fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .flush    (bus.i_flush),
        .push_req (bus.i_valid),
        .pop_req  (bus.i_ready),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .push     (push)
    );

    // Storage is deliberately unreset; empty masks whatever it holds.
    always_ff @(posedge i_clock) begin
        if (push)
            mem[wr_ptr] <= '{inst: bus.i_inst, compressed: bus.i_instCompressed, pc: bus.i_pc};
    end

    always_comb begin
        head = EMPTY_ENTRY;
        if (!empty) head = mem[rd_ptr];
    end

    assign bus.o_ready          = !full;
    assign bus.o_valid          = !empty;
    assign bus.o_count          = count;
    assign bus.o_inst           = head.inst;
    assign bus.o_instCompressed = head.compressed;
    assign bus.o_pc             = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against an in-order queue model.
// Model updates on the rising edge; outputs are compared on the falling edge.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain FIFO of entries capped at DEPTH.
    FetchEntry model[$];
    bit        m_push, m_pop;
    FetchEntry exp_head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.i_flush) begin
            model.delete();
        end else begin
            m_push = bus.i_valid && (model.size() < DEPTH);
            m_pop  = bus.i_ready && (model.size() > 0);
            if (m_pop) void'(model.pop_front());
            if (m_push) model.push_back('{inst: bus.i_inst, compressed: bus.i_instCompressed, pc: bus.i_pc});
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            exp_head = (model.size() > 0) ? model[0] : '{inst: 32'h13, compressed: 1'b0, pc: 32'h0};
            check("count", 32'(bus.o_count), 32'(model.size()));
            check("valid", 32'(bus.o_valid), 32'(model.size() > 0));
            check("ready", 32'(bus.o_ready), 32'(model.size() < DEPTH));
            check("head_inst", bus.o_inst, exp_head.inst);
            check("head_pc", bus.o_pc, exp_head.pc);
            check("head_c", 32'(bus.o_instCompressed), 32'(exp_head.compressed));
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input bit c, input bit rdy, input bit fl);
        bus.i_valid          = v;
        bus.i_pc             = pc;
        bus.i_inst           = inst;
        bus.i_instCompressed = c;
        bus.i_ready          = rdy;
        bus.i_flush          = fl;
        @(negedge clk);
    endtask

    initial begin
        bus.i_valid = 0; bus.i_pc = 0; bus.i_inst = 0;
        bus.i_instCompressed = 0; bus.i_ready = 0; bus.i_flush = 0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_inst", bus.o_inst, 32'h13);

        // Single entry visible one cycle after push
        drive(1, 32'h100, 32'h0050_0093, 0, 0, 0);
        check("one_valid", 32'(bus.o_valid), 32'd1);
        check("one_pc", bus.o_pc, 32'h100);
        check("one_count", 32'(bus.o_count), 32'd1);
        check("one_inst", bus.o_inst, 32'h0050_0093);
        drive(0, 0, 0, 0, 1, 0);
        check("one_drained", 32'(bus.o_count), 32'd0);

        // Fill and stall
        for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 32'h1000_0000 + 32'(i), 0, 0, 0);
        check("full_count", 32'(bus.o_count), 32'd4);
        check("full_ready", 32'(bus.o_ready), 32'd0);
        drive(1, 32'h10, 32'hdead_beef, 0, 0, 0);
        check("fifth_pc", bus.o_pc, 32'h0);
        check("fifth_count", 32'(bus.o_count), 32'd4);
        drive(0, 0, 0, 0, 1, 0);
        check("unfull_ready", 32'(bus.o_ready), 32'd1);
        check("unfull_pc", bus.o_pc, 32'h4);
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        check("fill_drained", 32'(bus.o_count), 32'd0);

        // Streaming: one in, one out each cycle
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h200 + 32'(i * 4), 32'h2000_0000 + 32'(i), 0, 1, 0);
            check("stream_count", 32'(bus.o_count), 32'd1);
            check("stream_pc", bus.o_pc, 32'h200 + 32'(i * 4));
        end
        drive(0, 0, 0, 0, 1, 0);
        check("stream_drained", 32'(bus.o_count), 32'd0);

        // Wrap-around: 6 pushes and 6 pops interleaved
        for (int i = 0; i < 7; i++) begin
            drive(i < 6, 32'h1e + 32'(i * 4), 32'h3000_0000 + 32'(i), i == 1, i > 0, 0);
            if (i == 1) begin
                check("wrap_c_pc", bus.o_pc, 32'h22);
                check("wrap_c_flag", 32'(bus.o_instCompressed), 32'd1);
            end
        end
        check("wrap_count", 32'(bus.o_count), 32'd0);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) drive(1, 32'h30 + 32'(i * 4), 32'h4000_0000 + 32'(i), 0, 0, 0);
        check("pre_flush_count", 32'(bus.o_count), 32'd3);
        drive(1, 32'h40, 32'h4000_0040, 0, 1, 1);
        check("flush_count", 32'(bus.o_count), 32'd0);
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        drive(1, 32'h80, 32'h4000_0080, 0, 0, 0);
        check("post_flush_pc", bus.o_pc, 32'h80);
        check("post_flush_valid", 32'(bus.o_valid), 32'd1);
        drive(0, 0, 0, 0, 1, 0);

        // Random traffic including occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset with a full queue
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, 32'h500 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1, 0, 0);
        check("ar_full", 32'(bus.o_count), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.o_valid), 32'd0);
        check("ar_ready", 32'(bus.o_ready), 32'd1);
        check("ar_count", 32'(bus.o_count), 32'd0);
        check("ar_inst", bus.o_inst, 32'h13);
        check("ar_pc", bus.o_pc, 32'h0);
        check("ar_c", 32'(bus.o_instCompressed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h300, 32'h6000_0000, 0, 0, 0);
        check("ar_push_valid", 32'(bus.o_valid), 32'd1);
        check("ar_push_pc", bus.o_pc, 32'h300);
        check("ar_push_count", 32'(bus.o_count), 32'd1);
        drive(0, 0, 0, 0, 1, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
